// File: rtl/turbo_lane_permute.sv
// turbo_lane_permute: LANES-way soft-value permutation stage, two-stage valid/ready pipeline.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready, data_in,     input beat: LANES lanes of WIDTH bits, LANES selects of SEL_W bits,
//   perm_in, mode                   mode 0 = gather (out[k]=in[perm[k]]), 1 = scatter (out[perm[i]]=in[i])
//   out_valid/out_ready, data_out,  output beat with frame-last and per-beat permutation error flags
//   out_last, out_err
//   err_sticky, err_clr             OR of transferred out_err since reset/clear; clear input
module turbo_lane_permute #(
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned LANES       = 8,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned FRAME_BEATS = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*LANES-1:0] data_in,
    input  logic [SEL_W*LANES-1:0] perm_in,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*LANES-1:0] data_out,
    output logic                   out_last,
    output logic                   out_err,
    output logic                   err_sticky,
    input  logic                   err_clr
);

    localparam int unsigned DW    = WIDTH * LANES;
    localparam int unsigned PW    = SEL_W * LANES;
    localparam int unsigned CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_BEATS - 1);
    // One extra bit so LANES is representable even when SEL_W == clog2(LANES)
    localparam logic [SEL_W:0]   LANES_SEL = (SEL_W + 1)'(LANES);

    logic             s1_valid;
    logic [DW-1:0]    s1_data;
    logic [PW-1:0]    s1_perm;
    logic             s1_mode;
    logic [CNT_W-1:0] beat_cnt;

    logic [DW-1:0]    perm_data;
    logic             perm_err;
    logic [LANES-1:0] hit;
    logic [SEL_W-1:0] sel;
    logic             s2_load;
    logic             accept;

    assign in_ready = rst_n && (!s1_valid || !out_valid || out_ready);
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Permutation network on the S1 beat; full compare against every lane index keeps
    // out-of-range selects (including extra upper SEL_W bits) out of the data path.
    always_comb begin
        perm_data = '0;
        perm_err  = 1'b0;
        hit       = '0;
        sel       = '0;
        if (!s1_mode) begin
            for (int k = 0; k < LANES; k++) begin
                sel = s1_perm[k*SEL_W +: SEL_W];
                if ({1'b0, sel} >= LANES_SEL) begin
                    perm_err = 1'b1;
                end
                for (int j = 0; j < LANES; j++) begin
                    if (sel == SEL_W'(j)) begin
                        perm_data[k*WIDTH +: WIDTH] = s1_data[j*WIDTH +: WIDTH];
                    end
                end
            end
        end else begin
            // Ascending source order: the highest colliding source lane wins.
            for (int i = 0; i < LANES; i++) begin
                sel = s1_perm[i*SEL_W +: SEL_W];
                if ({1'b0, sel} >= LANES_SEL) begin
                    perm_err = 1'b1;
                end
                for (int j = 0; j < LANES; j++) begin
                    if (sel == SEL_W'(j)) begin
                        if (hit[j]) begin
                            perm_err = 1'b1;
                        end
                        hit[j] = 1'b1;
                        perm_data[j*WIDTH +: WIDTH] = s1_data[i*WIDTH +: WIDTH];
                    end
                end
            end
            if (hit != {LANES{1'b1}}) begin
                perm_err = 1'b1;
            end
        end
    end

    // S1 capture, S2 output register, frame position and sticky error.
    // beat_cnt counts beats entering S2; load order equals transfer order and reset
    // flushes both stages together, so it always holds the frame position of the next emitted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_perm    <= '0;
            s1_mode    <= 1'b0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
            err_sticky <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= data_in;
                s1_perm  <= perm_in;
                s1_mode  <= mode;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= 1'b1;
                data_out  <= perm_data;
                out_err   <= perm_err;
                out_last  <= (beat_cnt == LAST_CNT);
                beat_cnt  <= (beat_cnt == LAST_CNT) ? '0 : beat_cnt + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Set has priority over clear.
            if (out_valid && out_ready && out_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_turbo_lane_permute.sv
// tb_turbo_lane_permute: directed vectors for an 8-lane instance (FRAME_BEATS=64)
// and a 6-lane instance (FRAME_BEATS=4) of turbo_lane_permute.
module tb_turbo_lane_permute;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-lane instance
    logic        rst_n, in_valid, in_ready, mode, out_valid, out_ready;
    logic        out_last, out_err, err_sticky, err_clr;
    logic [47:0] data_in, data_out;
    logic [23:0] perm_in;

    // 6-lane instance
    logic        rst_n6, in_valid6, in_ready6, mode6, out_valid6, out_ready6;
    logic        out_last6, out_err6, err_sticky6, err_clr6;
    logic [35:0] data_in6, data_out6;
    logic [17:0] perm_in6;

    turbo_lane_permute #(.WIDTH(6), .LANES(8), .SEL_W(3), .FRAME_BEATS(64)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .perm_in(perm_in), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .out_last(out_last), .out_err(out_err), .err_sticky(err_sticky), .err_clr(err_clr)
    );

    turbo_lane_permute #(.WIDTH(6), .LANES(6), .SEL_W(3), .FRAME_BEATS(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n6), .in_valid(in_valid6), .in_ready(in_ready6),
        .data_in(data_in6), .perm_in(perm_in6), .mode(mode6),
        .out_valid(out_valid6), .out_ready(out_ready6), .data_out(data_out6),
        .out_last(out_last6), .out_err(out_err6), .err_sticky(err_sticky6), .err_clr(err_clr6)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // lane j = start + step*j (6-bit wrap)
    function automatic logic [47:0] seq8(input int start, input int step);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[j*6 +: 6] = 6'(start + step * j);
        return r;
    endfunction

    // select k = start + step*k (3-bit wrap)
    function automatic logic [23:0] p8(input int start, input int step);
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k*3 +: 3] = 3'(start + step * k);
        return r;
    endfunction

    function automatic logic [47:0] rev8(input logic [47:0] d);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[j*6 +: 6] = d[(7-j)*6 +: 6];
        return r;
    endfunction

    typedef struct {
        string       name;
        logic        mode;
        logic [23:0] perm;
        logic [47:0] data;
        logic [47:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    // single beat on the 8-lane instance, out_ready held 1
    task automatic beat8(input vec_t v);
        @(negedge clk);
        mode = v.mode; perm_in = v.perm; data_in = v.data; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({v.name, "_lat1"}, 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        #1;
        chk({v.name, "_valid"}, 64'(out_valid), 64'(1'b1));
        chk({v.name, "_data"},  64'(data_out),  64'(v.exp));
        chk({v.name, "_err"},   64'(out_err),   64'(v.err));
    endtask

    task automatic beat6(input string name, input logic md, input logic [17:0] p,
                         input logic [35:0] d, input logic [35:0] e, input logic er);
        @(negedge clk);
        mode6 = md; perm_in6 = p; data_in6 = d; in_valid6 = 1'b1;
        @(negedge clk);
        in_valid6 = 1'b0;
        @(negedge clk);
        #1;
        chk({name, "_valid"}, 64'(out_valid6), 64'(1'b1));
        chk({name, "_data"},  64'(data_out6),  64'(e));
        chk({name, "_err"},   64'(out_err6),   64'(er));
    endtask

    // 10-beat stream, out_ready pattern 1,0,0,1; gather with reversing perm
    task automatic stream8();
        int sent, recv;
        logic held;
        logic [47:0] held_data;
        sent = 0; recv = 0; held = 1'b0; held_data = '0;
        mode = 1'b0; perm_in = p8(7, -1);
        for (int c = 0; c < 200 && recv < 10; c++) begin
            @(negedge clk);
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            if (sent < 10) begin
                in_valid = 1'b1; data_in = seq8(sent * 7 + 1, 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) chk("stream_hold", 64'(data_out), 64'(held_data));
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk("stream_data", 64'(data_out), 64'(rev8(seq8(recv * 7 + 1, 1))));
                recv++;
            end
            held = out_valid && !out_ready;
            held_data = data_out;
        end
        chk("stream_count", 64'(recv), 64'(10));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("stream_no_dup", 64'(out_valid), 64'(1'b0));
    endtask

    // stream on the 6-lane instance; stops once n_recv beats have been seen transferring
    task automatic stream6(input int n_send, input int n_recv, input int base);
        int sent, recv;
        logic [5:0] v;
        sent = 0; recv = 0;
        mode6 = 1'b0; perm_in6 = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        for (int c = 0; c < 200 && recv < n_recv; c++) begin
            @(negedge clk);
            out_ready6 = 1'b1;
            if (sent < n_send) begin
                v = 6'(base + sent);
                in_valid6 = 1'b1; data_in6 = {6{v}};
            end else begin
                in_valid6 = 1'b0;
            end
            #1;
            if (in_valid6 && in_ready6) sent++;
            if (out_valid6 && out_ready6) begin
                v = 6'(base + recv);
                chk("frame_data", 64'(data_out6), 64'({6{v}}));
                chk("frame_last", 64'(out_last6), 64'((recv % 4) == 3));
                recv++;
            end
        end
        chk("frame_count", 64'(recv), 64'(n_recv));
    endtask

    initial begin
        vecs[0] = '{"gather_id",   1'b0, p8(0, 1),  seq8(1, 1), seq8(1, 1),  1'b0};
        vecs[1] = '{"gather_rev",  1'b0, p8(7, -1), seq8(1, 1), seq8(8, -1), 1'b0};
        vecs[2] = '{"scatter_rev", 1'b1, p8(7, -1), seq8(1, 1), seq8(8, -1), 1'b0};
        vecs[3] = '{"scatter_col", 1'b1,
                    {3'd7, 3'd6, 3'd5, 3'd4, 3'd1, 3'd0, 3'd3, 3'd3}, seq8(1, 1),
                    {6'd8, 6'd7, 6'd6, 6'd5, 6'd2, 6'd0, 6'd4, 6'd3}, 1'b1};
        vecs[4] = '{"gather_dup",  1'b0, p8(5, 0),  seq8(1, 1), seq8(6, 0),  1'b0};
        vecs[5] = '{"gather_rot",  1'b0, p8(1, 1),  seq8(1, 1),
                    {6'd1, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2}, 1'b0};
        vecs[6] = '{"scatter_rot", 1'b1, p8(1, 1),  seq8(1, 1),
                    {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd8}, 1'b0};
        vecs[7] = '{"round_trip",  1'b1, p8(1, 1),
                    {6'd1, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2}, seq8(1, 1), 1'b0};
        vecs[8] = '{"raw_bits",    1'b0, p8(0, 1),
                    {6'd42, 6'd15, 6'd48, 6'd0, 6'd1, 6'd31, 6'd32, 6'd63},
                    {6'd42, 6'd15, 6'd48, 6'd0, 6'd1, 6'd31, 6'd32, 6'd63}, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        data_in = '0; perm_in = '0;
        rst_n6 = 1'b0; in_valid6 = 1'b0; mode6 = 1'b0; out_ready6 = 1'b1; err_clr6 = 1'b0;
        data_in6 = '0; perm_in6 = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid",  64'(out_valid),  64'(1'b0));
        chk("rst_data_out",   64'(data_out),   64'(0));
        chk("rst_out_last",   64'(out_last),   64'(1'b0));
        chk("rst_out_err",    64'(out_err),    64'(1'b0));
        chk("rst_err_sticky", 64'(err_sticky), 64'(1'b0));
        chk("rst_in_ready",   64'(in_ready),   64'(1'b0));
        chk("rst_in_ready6",  64'(in_ready6),  64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1; rst_n6 = 1'b1;

        for (int i = 0; i < 9; i++) beat8(vecs[i]);

        // sticky error from the collision vector, then clear
        @(negedge clk);
        #1;
        chk("sticky_set", 64'(err_sticky), 64'(1'b1));
        chk("drained",    64'(out_valid),  64'(1'b0));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1 chk("sticky_clr", 64'(err_sticky), 64'(1'b0));

        // errored beat held under stall, second beat fills S1, then clear coincides with transfer
        out_ready = 1'b0;
        mode = vecs[3].mode; perm_in = vecs[3].perm; data_in = vecs[3].data; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("stall_valid",     64'(out_valid),  64'(1'b1));
        chk("stall_err",       64'(out_err),    64'(1'b1));
        chk("stall_no_sticky", 64'(err_sticky), 64'(1'b0));
        mode = 1'b0; perm_in = p8(0, 1); data_in = seq8(1, 1); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", 64'(in_ready), 64'(1'b0));
        chk("stall_data",    64'(data_out), 64'(vecs[3].exp));
        out_ready = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("set_wins",    64'(err_sticky), 64'(1'b1));
        chk("second_valid", 64'(out_valid), 64'(1'b1));
        chk("second_data", 64'(data_out),   64'(seq8(1, 1)));
        chk("second_err",  64'(out_err),    64'(1'b0));
        @(negedge clk);
        #1 chk("second_gone", 64'(out_valid), 64'(1'b0));

        stream8();

        // 6-lane range checks
        beat6("g6_oor", 1'b0, {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
              {6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, {6'd0, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, 1'b1);
        beat6("s6_oor", 1'b1, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd6},
              {6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, {6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd0}, 1'b1);
        beat6("g6_id", 1'b0, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
              {6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, {6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, 1'b0);

        // frame of 4: 9 beats, last on 4 and 8
        @(negedge clk);
        rst_n6 = 1'b0; in_valid6 = 1'b0;
        @(negedge clk);
        #1;
        chk("frm_rst_valid", 64'(out_valid6), 64'(1'b0));
        chk("frm_rst_ready", 64'(in_ready6),  64'(1'b0));
        rst_n6 = 1'b1;
        stream6(9, 9, 10);

        // reset after beat 6 with beats in flight
        @(negedge clk);
        rst_n6 = 1'b0;
        @(negedge clk);
        rst_n6 = 1'b1;
        stream6(8, 6, 20);
        @(negedge clk);
        rst_n6 = 1'b0; in_valid6 = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", 64'(out_valid6), 64'(1'b0));
        chk("mid_rst_last",  64'(out_last6),  64'(1'b0));
        rst_n6 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("no_partial", 64'(out_valid6), 64'(1'b0));
        end
        stream6(4, 4, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
